mmc1_load_seq: RTL and testbench
================================

// Module: mmc1_load_seq
// PURPOSE
//  Host-side sequencer that loads one MMC1 mapper register through its 5-write serial port.
//  Takes {register, 5-bit value} requests and drives a synthetic CPU bus: M2, CE_N, RW, A14:13, D0, D7.
//  Inserts a read (gap) cycle before every write so the mapper's consecutive-write filter never drops a bit.
//  Sits between the menu/save-state controller and the mapper's CPU-side bus mux; bus_own selects this block.
// PARAMETERS
//  M2_HI_CLK  4  clk cycles M2 is high per bus cycle; minimum 1
//  M2_LO_CLK  4  clk cycles M2 is low per bus cycle; minimum 1
// PORTS
//  clk        in   1  system clock; everything is synchronous to its rising edge
//  rst_n      in   1  synchronous, active-low reset
//  req_valid  in   1  load request
//  req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
//  req_reg    in   2  target register: 0 CTRL, 1 CHR0, 2 CHR1, 3 PRG
//  req_val    in   5  value to load; bit 0 is shifted first
//  busy       out  1  sequence in progress
//  done       out  1  one-clk pulse when the last write cycle completes
//  bus_own    out  1  1 = mux selects this block's bus outputs
//  bus_m2     out  1  synthetic M2; the mapper latches on its falling edge
//  bus_ce_n   out  1  PRG /CE; 0 on write cycles, 1 on gap cycles
//  bus_rw     out  1  0 on write cycles, 1 otherwise
//  bus_addr   out  2  A14:13 = req_reg during the sequence, 0 otherwise
//  bus_d0     out  1  serial data bit
//  bus_d7     out  1  shift-register reset bit
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE; req_ready=1; busy=0; done=0; bus_own=0; bus_m2=0;
//   bus_ce_n=1; bus_rw=1; bus_addr=0; bus_d0=0; bus_d7=0. Reset mid-sequence aborts on that edge;
//   a partial shift is left in the mapper and the next request (or the macro below) clears it.
//  Accept: req_reg and req_val are captured; later input changes are ignored until done.
//  States: IDLE -> HI -> LO -> (HI of next bus cycle | DONE) ; DONE -> IDLE after 1 clk.
//  Bus cycle k = M2_HI_CLK clks in HI (m2=1), then M2_LO_CLK clks in LO (m2=0).
//   ce_n, rw, addr, d0 and d7 are set on entry to HI and held through LO.
//   The mapper samples on the HI->LO edge.
//  Bus cycle list, index counter 0..N-1: G, W0, G, W1, G, W2, G, W3, G, W4 (N=10).
//   G  = gap: rw=1, ce_n=1, d0=0, d7=0.
//   Wi = write: rw=0, ce_n=0, d7=0, d0 = req_val[i].
//  Latency: accept edge to done pulse = N*(M2_HI_CLK+M2_LO_CLK) clks (default 80).
//  done is asserted in DONE. busy=bus_own=1 in HI, LO and DONE.
//   DONE drives the idle bus: m2=0, rw=1, ce_n=1.
//  Back-to-back: after the DONE clk, IDLE re-asserts req_ready.
//   A held req_valid is accepted 1 clk after done.
//  Phase counter width = $clog2(max(M2_HI_CLK, M2_LO_CLK)+1). It wraps to 0 at each phase end.
//   The index counter only increments at LO end.
//  Parameter value 0 is illegal: elaboration-time assertion.
// CONFIGURATION
//  MMC1_LOAD_RESET_EN defined: list becomes G, R, G, W0 ... W4 (N=12; default latency 96).
//   R = reset write: rw=0, ce_n=0, d7=1, d0=0. It clears any partial shift left by an aborted sequence.
//  Undefined: N=10 list only; no d7=1 cycle is ever issued.
// STRUCTURE
//  mmc1_pkg (shared):
//   - typedef enum {IDLE, HI, LO, DONE} seq_state_t
//   - typedef enum {CYC_GAP, CYC_RST, CYC_WR} cyc_kind_t
//   - localparams REG_CTRL=0, REG_CHR0=1, REG_CHR1=2, REG_PRG=3
//  Sub-module mmc1_m2_timer (params M2_HI_CLK, M2_LO_CLK):
//   - phase counter; outputs m2 level, hi_end and lo_end strobes
//   - the top level holds the FSM, index counter and cycle decode
// TESTING
//  Common: a bench model of the MMC1 serial port (5-bit shift, d7 clear, consecutive-write filter)
//   is attached to the bus outputs.
//  1 Reset: hold rst_n=0 for 3 clk -> all outputs at their reset values; req_ready=1.
//  2 req_reg=0, req_val=0x0C -> write cycles carry d0 = 0,0,1,1,0 with addr=0; every gap has rw=1, ce_n=1;
//    done exactly 80 clk after accept; model CTRL=0x0C.
//  3 req_reg=3, req_val=0x15, then req_reg=1, req_val=0x0A with req_valid held ->
//    second accept 1 clk after the first done; model PRG=0x15, CHR0=0x0A.
//  4 rst_n=0 for 1 clk at clk 30 of a request -> next clk bus_own=0, m2=0, busy=0, req_ready=1;
//    a new request (0x1F to reg 2) completes normally.
//  5 MMC1_LOAD_RESET_EN, M2_HI_CLK=1, M2_LO_CLK=2:
//    bus cycle 1 has d7=1, rw=0; done after 36 clk; model CHR1 correct after injected partial shift.
//  6 Change req_val/req_reg mid-sequence -> written value and address equal the accepted ones.

Source files
------------

// File: rtl/mmc1_pkg.sv
// Shared types and bus-cycle decode for the MMC1 serial-port load sequencer.
// MMC1_LOAD_RESET_EN prepends a gap plus a d7=1 reset write to every load sequence.
package mmc1_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} seq_state_t;
  typedef enum logic [1:0] {CYC_GAP, CYC_RST, CYC_WR} cyc_kind_t;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

`ifdef MMC1_LOAD_RESET_EN
  localparam int CYC_OFS = 2;
`else
  localparam int CYC_OFS = 0;
`endif
  localparam int N_CYC = 10 + CYC_OFS;

  // Even indices are gaps; with the reset option, index 1 is the reset write.
  function automatic cyc_kind_t cyc_kind(input logic [3:0] idx);
    if (!idx[0]) return CYC_GAP;
    if (CYC_OFS != 0 && idx == 4'd1) return CYC_RST;
    return CYC_WR;
  endfunction

  function automatic logic [2:0] wr_bit(input logic [3:0] idx);
    return 3'((idx - 4'(1 + CYC_OFS)) >> 1);
  endfunction

endpackage

// File: rtl/mmc1_m2_timer.sv
// M2 phase timer: counts clocks in the HI and LO halves of each synthetic bus cycle.
module mmc1_m2_timer #(
  parameter int M2_HI_CLK = 4,
  parameter int M2_LO_CLK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic phase_hi,
  output logic m2,
  output logic hi_end,
  output logic lo_end
);

  localparam int MAX_CLK = (M2_HI_CLK > M2_LO_CLK) ? M2_HI_CLK : M2_LO_CLK;
  localparam int W = $clog2(MAX_CLK + 1);

  generate
    if (M2_HI_CLK < 1 || M2_LO_CLK < 1) begin : g_bad_param
      $error("mmc1_m2_timer: M2_HI_CLK and M2_LO_CLK must be at least 1");
    end
  endgenerate

  logic [W-1:0] cnt;
  logic         last;

  assign last = phase_hi ? (cnt == W'(M2_HI_CLK - 1)) : (cnt == W'(M2_LO_CLK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !run) cnt <= '0;
    else if (last)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  assign m2     = run & phase_hi;
  assign hi_end = run & phase_hi & last;
  assign lo_end = run & ~phase_hi & last;

endmodule

// File: rtl/mmc1_load_seq.sv
// Loads one MMC1 register over its 5-write serial port, with a gap cycle before every write.
// MMC1_LOAD_RESET_EN adds a leading d7=1 reset write (12 bus cycles instead of 10).
module mmc1_load_seq
  import mmc1_pkg::*;
#(
  parameter int M2_HI_CLK = 4,
  parameter int M2_LO_CLK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_reg,
  input  logic [4:0] req_val,
  output logic       busy,
  output logic       done,
  output logic       bus_own,
  output logic       bus_m2,
  output logic       bus_ce_n,
  output logic       bus_rw,
  output logic [1:0] bus_addr,
  output logic       bus_d0,
  output logic       bus_d7,
  output seq_state_t seq_state
);

  // Handshake: a request is taken on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, and req_valid may be held across done.
  seq_state_t state, state_next;
  logic [3:0] idx;
  logic [1:0] reg_q;
  logic [4:0] val_q;
  logic       accept, run, phase_hi, hi_end, lo_end;

  assign accept    = req_valid & req_ready;
  assign run       = (state == HI) || (state == LO);
  assign phase_hi  = (state == HI);
  assign seq_state = state;

  mmc1_m2_timer #(
    .M2_HI_CLK(M2_HI_CLK),
    .M2_LO_CLK(M2_LO_CLK)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .phase_hi(phase_hi),
    .m2      (bus_m2),
    .hi_end  (hi_end),
    .lo_end  (lo_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      reg_q <= '0;
      val_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        reg_q <= req_reg;
        val_q <= req_val;
        idx   <= '0;
      end else if (lo_end) begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = HI;
      HI:   if (hi_end) state_next = LO;
      LO:   if (lo_end) state_next = (idx == 4'(N_CYC - 1)) ? DONE : HI;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields follow the cycle index, so they change on entry to HI and hold through LO.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = 1'b0;
    done      = 1'b0;
    bus_own   = 1'b0;
    bus_ce_n  = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = 2'd0;
    bus_d0    = 1'b0;
    bus_d7    = 1'b0;
    if (run) begin
      busy     = 1'b1;
      bus_own  = 1'b1;
      bus_addr = reg_q;
      case (cyc_kind(idx))
        CYC_RST: begin
          bus_ce_n = 1'b0;
          bus_rw   = 1'b0;
          bus_d7   = 1'b1;
        end
        CYC_WR: begin
          bus_ce_n = 1'b0;
          bus_rw   = 1'b0;
          bus_d0   = val_q[wr_bit(idx)];
        end
        default: ;
      endcase
    end else if (state == DONE) begin
      busy    = 1'b1;
      bus_own = 1'b1;
      done    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mmc1_load_seq.sv
// Bench for mmc1_load_seq: MMC1 serial-port model on the bus, scoreboard on done.
// Build with MMC1_LOAD_RESET_EN to exercise the reset-write variant at M2 timing 1/2.
module tb_mmc1_load_seq;
  import mmc1_pkg::*;

`ifdef MMC1_LOAD_RESET_EN
  localparam int HI_C = 1, LO_C = 2, N_EXP = 12, LAT = 36, EXP_RST_IDX = 1;
`else
  localparam int HI_C = 4, LO_C = 4, N_EXP = 10, LAT = 80, EXP_RST_IDX = -1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_reg;
  logic [4:0] req_val;
  logic       busy, done, bus_own, bus_m2, bus_ce_n, bus_rw, bus_d0, bus_d7;
  logic [1:0] bus_addr;
  seq_state_t seq_state;

  mmc1_load_seq #(.M2_HI_CLK(HI_C), .M2_LO_CLK(LO_C)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .busy(busy), .done(done),
    .bus_own(bus_own), .bus_m2(bus_m2), .bus_ce_n(bus_ce_n), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_d0(bus_d0), .bus_d7(bus_d7), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard state
  logic [6:0] exp_q[$];
  int         acc_q[$];
  int         acc_log[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  logic [6:0] e;
  int         a;

  // MMC1 serial-port model and per-sequence bus capture
  logic [4:0] mreg[4];
  logic [4:0] msh;
  int         mcnt;
  bit         last_wr;
  logic       prev_m2 = 1'b0;
  logic [4:0] seq_val;
  logic [1:0] seq_addr;
  int         seq_wr, seq_cyc, seq_rst_idx;

  task automatic clear_seq();
    seq_val = '0; seq_addr = '0; seq_wr = 0; seq_cyc = 0; seq_rst_idx = -1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (prev_m2 && !bus_m2) begin
      if (bus_rw) begin
        chk("gap_ce_n", bus_ce_n, 1);
        chk("gap_d7", bus_d7, 0);
        chk("gap_d0", bus_d0, 0);
        last_wr = 1'b0;
      end else begin
        chk("wr_ce_n", bus_ce_n, 0);
        if (bus_d7) begin
          if (seq_rst_idx < 0) seq_rst_idx = seq_cyc;
        end else begin
          if (seq_wr < 5) seq_val[seq_wr] = bus_d0;
          seq_wr++;
          seq_addr = bus_addr;
        end
        // Consecutive-write filter: a write right after a write is ignored.
        if (!last_wr) begin
          if (bus_d7) begin
            msh = '0; mcnt = 0;
          end else begin
            msh = {bus_d0, msh[4:1]};
            mcnt++;
            if (mcnt == 5) begin
              mreg[bus_addr] = msh; msh = '0; mcnt = 0;
            end
          end
        end
        last_wr = 1'b1;
      end
      seq_cyc++;
    end
    prev_m2 = bus_m2;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("latency", cyc - a, LAT);
        chk("seq_val", seq_val, e[4:0]);
        chk("seq_addr", seq_addr, e[6:5]);
        chk("n_writes", seq_wr, 5);
        chk("n_bus_cycles", seq_cyc, N_EXP);
        chk("rst_cycle_idx", seq_rst_idx, EXP_RST_IDX);
      end
      clear_seq();
    end
  end

  task automatic wait_accept();
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!req_ready && k < 400);
    if (!req_ready) chk("accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [1:0] r, input logic [4:0] v, input bit expect_done);
    @(negedge clk);
    req_valid = 1'b1; req_reg = r; req_val = v;
    if (expect_done) exp_q.push_back({r, v});
    wait_accept();
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 3 * LAT) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a1, a2;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    msh = '0; mcnt = 0; last_wr = 1'b0;
    clear_seq();
    rst_n = 1'b0; req_valid = 1'b0; req_reg = '0; req_val = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_own", bus_own, 0);
    chk("rst_m2", bus_m2, 0);
    chk("rst_ce_n", bus_ce_n, 1);
    chk("rst_rw", bus_rw, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_d0", bus_d0, 0);
    chk("rst_d7", bus_d7, 0);
    rst_n = 1'b1;

    // Single load of CTRL = 0x0C (d0 sequence 0,0,1,1,0)
    issue(REG_CTRL, 5'h0C, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    wait_done(1);
    chk("model_ctrl", mreg[0], 5'h0C);

    // Back-to-back with req_valid held: PRG = 0x15, then CHR0 = 0x0A
    issue(REG_PRG, 5'h15, 1'b1);
    @(negedge clk);
    req_reg = REG_CHR0; req_val = 5'h0A;
    exp_q.push_back({REG_CHR0, 5'h0A});
    wait_accept();
    @(negedge clk); req_valid = 1'b0;
    a1 = acc_log[acc_log.size() - 2];
    a2 = acc_log[acc_log.size() - 1];
    // done occupies one clk, IDLE the next; the held request is taken at the edge after that.
    chk("b2b_accept_gap", a2 - a1, LAT + 2);
    chk("b2b_after_done", a2 - last_done_cyc, 2);
    wait_done(3);
    chk("model_prg", mreg[3], 5'h15);
    chk("model_chr0", mreg[1], 5'h0A);

    // Abort with reset at clk 30 of a request, then load CHR1 = 0x1F
    issue(REG_CHR1, 5'h03, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_bus_own", bus_own, 0);
    chk("abort_m2", bus_m2, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    @(posedge clk);
    acc_q.delete();
    clear_seq();
`ifndef MMC1_LOAD_RESET_EN
    // Without the reset write the host must resync the mapper itself.
    msh = '0; mcnt = 0;
`endif
    issue(REG_CHR1, 5'h1F, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    wait_done(4);
    chk("model_chr1", mreg[2], 5'h1F);

    // Inputs changing mid-sequence are ignored
    issue(REG_CTRL, 5'h13, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_reg = 2'(i); req_val = 5'(i * 7);
    end
    wait_done(5);
    chk("model_ctrl_hold", mreg[0], 5'h13);
    chk("model_prg_untouched", mreg[3], 5'h15);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("idle_done_low", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
